// File: rtl/fpu_pkg.sv
// ============================================================================
//  fpu_pkg : shared encodings and constants for the float/int conversion blocks
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package fpu_pkg;

  typedef enum logic [2:0] {
    ST_GET_A   = 3'd0,
    ST_UNPACK  = 3'd1,
    ST_SPECIAL = 3'd2,
    ST_CONVERT = 3'd3,
    ST_PUT_Z   = 3'd4
  } state_t;

  localparam int          FLOAT_BIAS  = 127;
  localparam logic [31:0] INT_INVALID = 32'h8000_0000;

endpackage : fpu_pkg

`default_nettype wire

// File: rtl/float_to_int.sv
// ============================================================================
//  float_to_int : single-precision float to signed 32-bit int, truncating,
//                 one operand in flight, one-bit-per-cycle normalising shifter
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module float_to_int
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  state_t             r_state;
  state_t             w_state_next;
  logic               r_input_a_ack;
  logic               w_input_a_ack_next;
  logic               r_output_z_stb;
  logic               w_output_z_stb_next;
  logic [31:0]        r_output_z;

  logic [31:0]        r_a;
  logic [31:0]        r_m;
  logic signed [9:0]  r_e;
  logic               r_s;
  logic [31:0]        r_z;

  logic               w_accept;
  logic               w_deliver;

  assign w_accept     = r_input_a_ack && input_a_stb;
  assign w_deliver    = r_output_z_stb && output_z_ack;

  assign input_a_ack  = r_input_a_ack;
  assign output_z_stb = r_output_z_stb;
  assign output_z     = r_output_z;

  // Control state and handshake flags; only these are reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_GET_A;
      r_input_a_ack  <= 1'b0;
      r_output_z_stb <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_input_a_ack  <= w_input_a_ack_next;
      r_output_z_stb <= w_output_z_stb_next;
    end
  end

  always_comb begin
    w_state_next        = r_state;
    w_input_a_ack_next  = 1'b0;
    w_output_z_stb_next = 1'b0;
    case (r_state)
      ST_GET_A: begin
        w_input_a_ack_next = !w_accept;
        if (w_accept) begin
          w_state_next = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        w_state_next = ST_SPECIAL;
      end
      ST_SPECIAL: begin
        if ((r_e < 10'sd0) || (r_e > 10'sd30)) begin
          w_state_next = ST_PUT_Z;
        end else begin
          w_state_next = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (r_e == 10'sd31) begin
          w_state_next = ST_PUT_Z;
        end
      end
      ST_PUT_Z: begin
        w_output_z_stb_next = !w_deliver;
        if (w_deliver) begin
          w_state_next = ST_GET_A;
        end
      end
      default: begin
        w_state_next = ST_GET_A;
      end
    endcase
  end

  // Datapath is deliberately unreset; its contents only matter once PUT_Z is reached.
  always_ff @(posedge clk) begin
    case (r_state)
      ST_GET_A: begin
        if (w_accept) begin
          r_a <= input_a;
        end
      end
      ST_UNPACK: begin
        r_m <= {1'b1, r_a[22:0], 8'b0};
        r_e <= $signed({2'b00, r_a[30:23]}) - 10'(FLOAT_BIAS);
        r_s <= r_a[31];
      end
      ST_SPECIAL: begin
        if (r_e < 10'sd0) begin
          r_z <= 32'd0;
        end else if (r_e > 10'sd30) begin
          r_z <= INT_INVALID;
        end
      end
      ST_CONVERT: begin
        // Hidden bit sits at position 31, so e reaching 31 means the binary point is aligned.
        if (r_e < 10'sd31) begin
          r_m <= {1'b0, r_m[31:1]};
          r_e <= r_e + 10'sd1;
        end else begin
          r_z <= r_s ? (~r_m + 32'd1) : r_m;
        end
      end
      ST_PUT_Z: begin
        r_output_z <= r_z;
      end
      default: begin
      end
    endcase
  end

endmodule : float_to_int

`default_nettype wire
